load_store_unit: RTL and testbench

- Memory-stage access sequencer between the EX/MEM pipeline register and the byte-addressed 64-bit Data_Memory.
- Accepts one load or store per transaction via a valid/ready request handshake and executes it as a doubleword-aligned memory access.
- Sub-doubleword stores are performed as read-modify-write sequences.
- Loads return size-extracted, sign- or zero-extended results; misaligned and out-of-range accesses are reported as faults.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus shared by the
// EX/MEM pipeline side, the load/store unit and the data memory.
interface load_store_unit_if;

    // Request channel from the pipeline
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    // Response channel back to the pipeline
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_access_fault;

    // Doubleword data-memory bus
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_rdata;

    // View seen by the load/store unit
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output resp_access_fault, mem_addr, mem_wdata, mem_write, mem_read
    );

    // View seen by the pipeline and memory driving the unit
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  resp_access_fault, mem_addr, mem_wdata, mem_write, mem_read
    );

endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer. Turns one byte/half/word/double
// load or store into doubleword-aligned accesses on a 64-bit data
// memory, using read-modify-write for partial stores, and reports
// misaligned and out-of-range/illegal accesses without touching memory.
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;

    // Captured request
    logic        r_isWrite;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;

    // Registered response outputs
    logic        r_respValid;
    logic [63:0] r_respRdata;
    logic        r_respMisaligned;
    logic        r_respFault;

    // Registered memory bus outputs; r_memWdata doubles as the merge register
    logic [63:0] r_memAddr;
    logic [63:0] r_memWdata;
    logic        r_memWrite;
    logic        r_memRead;

    // Request decode
    logic        w_reqReady;
    logic        w_illegal;
    logic [2:0]  w_alignMask;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_isDouble;

    // Load extraction and store merge datapath
    logic [63:0] w_shifted;
    logic [63:0] w_loadData;
    logic [7:0]  w_sizeBytes;
    logic [7:0]  w_byteEnable;
    logic [63:0] w_wdataShifted;
    logic [63:0] w_merged;

    // Only an idle unit that is not being reset may take a request
    assign w_reqReady = (r_state == IDLE) && !reset;

    // Decode legality, alignment and range of the incoming request
    always_comb begin
        w_illegal    = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
        unique case (bus.req_funct3[1:0])
            2'b00:   w_alignMask = 3'b000;
            2'b01:   w_alignMask = 3'b001;
            2'b10:   w_alignMask = 3'b011;
            default: w_alignMask = 3'b111;
        endcase
        w_misaligned = (bus.req_addr[2:0] & w_alignMask) != 3'b000;
        w_outOfRange = bus.req_addr >= 64'(MEM_BYTES);
        w_isDouble   = bus.req_funct3[1:0] == 2'b11;
    end

    // Pick the addressed bytes out of the doubleword and extend them
    always_comb begin
        w_shifted = bus.mem_rdata >> {r_off, 3'b000};
        unique case (r_funct3[1:0])
            2'b00: w_loadData = r_funct3[2] ? {56'd0, w_shifted[7:0]}
                                            : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_loadData = r_funct3[2] ? {48'd0, w_shifted[15:0]}
                                            : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'b10: w_loadData = r_funct3[2] ? {32'd0, w_shifted[31:0]}
                                            : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // Overlay the store bytes onto the doubleword just read from memory
    always_comb begin
        unique case (r_funct3[1:0])
            2'b00:   w_sizeBytes = 8'h01;
            2'b01:   w_sizeBytes = 8'h03;
            2'b10:   w_sizeBytes = 8'h0F;
            default: w_sizeBytes = 8'hFF;
        endcase
        w_byteEnable   = w_sizeBytes << r_off;
        w_wdataShifted = r_wdata << {r_off, 3'b000};
        w_merged       = bus.mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (w_byteEnable[i]) begin
                w_merged[8*i +: 8] = w_wdataShifted[8*i +: 8];
            end
        end
    end

    // Transaction sequencer: accept, fault-check, read, write, respond
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_isWrite        <= 1'b0;
            r_funct3         <= 3'b000;
            r_off            <= 3'b000;
            r_wdata          <= 64'd0;
            r_respValid      <= 1'b0;
            r_respRdata      <= 64'd0;
            r_respMisaligned <= 1'b0;
            r_respFault      <= 1'b0;
            r_memAddr        <= 64'd0;
            r_memWdata       <= 64'd0;
            r_memWrite       <= 1'b0;
            r_memRead        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_isWrite        <= bus.req_write;
                        r_funct3         <= bus.req_funct3;
                        r_off            <= bus.req_addr[2:0];
                        r_wdata          <= bus.req_wdata;
                        r_respRdata      <= 64'd0;
                        r_respMisaligned <= 1'b0;
                        r_respFault      <= 1'b0;
                        if (w_illegal) begin
                            r_respFault <= 1'b1;
                            r_respValid <= 1'b1;
                            r_state     <= RESP;
                        end else if (w_misaligned) begin
                            r_respMisaligned <= 1'b1;
                            r_respValid      <= 1'b1;
                            r_state          <= RESP;
                        end else if (w_outOfRange) begin
                            r_respFault <= 1'b1;
                            r_respValid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_memAddr <= {bus.req_addr[63:3], 3'b000};
                            if (bus.req_write && w_isDouble) begin
                                r_memWdata <= bus.req_wdata;
                                r_memWrite <= 1'b1;
                                r_state    <= WRITE;
                            end else begin
                                r_memRead <= 1'b1;
                                r_state   <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    r_memRead <= 1'b0;
                    if (r_isWrite) begin
                        r_memWdata <= w_merged;
                        r_memWrite <= 1'b1;
                        r_state    <= WRITE;
                    end else begin
                        r_respRdata <= w_loadData;
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WRITE: begin
                    r_memWrite  <= 1'b0;
                    r_respValid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_respValid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready         = w_reqReady;
    assign bus.resp_valid        = r_respValid;
    assign bus.resp_rdata        = r_respRdata;
    assign bus.resp_misaligned   = r_respMisaligned;
    assign bus.resp_access_fault = r_respFault;
    assign bus.mem_addr          = r_memAddr;
    assign bus.mem_wdata         = r_memWdata;
    assign bus.mem_write         = r_memWrite && !reset;
    assign bus.mem_read          = r_memRead;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, directed steps
// followed by random transactions compared with a byte-level model.
module tb_load_store_unit;

    localparam int MEM_BYTES = 64;

    logic clock = 1'b0;
    logic reset;
    logic presetMem;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] envMem [MEM_BYTES];
    logic [7:0] refMem [MEM_BYTES];

    int assertCount = 0;
    int failCount   = 0;

    // Data memory: preset to DATA[i] = i, commit stores on the clock edge
    always @(posedge clock) begin
        if (presetMem) begin
            for (int i = 0; i < MEM_BYTES; i++) envMem[i] <= 8'(i);
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) envMem[{bus.mem_addr[5:3], 3'(i)}] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Combinational doubleword read
    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) bus.mem_rdata[8*i +: 8] = envMem[{bus.mem_addr[5:3], 3'(i)}];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: legality, alignment, range, then memory effect
    task automatic modelRequest(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wd, output logic [63:0] expData,
                                output logic expMis, output logic expFault, output int expLat,
                                output int expWrites, output int expReads);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        expData = 0; expMis = 0; expFault = 0; expLat = 1; expWrites = 0; expReads = 0;
        v = 0;
        if ((wr && f3 > 3) || (!wr && f3 == 3'd7)) begin
            expFault = 1;
        end else if ((addr % 64'(size)) != 0) begin
            expMis = 1;
        end else if (addr >= 64'(MEM_BYTES)) begin
            expFault = 1;
        end else if (wr) begin
            for (int i = 0; i < size; i++) refMem[int'(addr) + i] = wd[8*i +: 8];
            expWrites = 1;
            expReads  = (size == 8) ? 0 : 1;
            expLat    = (size == 8) ? 2 : 3;
        end else begin
            for (int i = 0; i < size; i++) v = v | (64'(refMem[int'(addr) + i]) << (8*i));
            if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
            expData  = v;
            expReads = 1;
            expLat   = 2;
        end
    endtask

    // Present a request at a falling edge and let the next rising edge accept it
    task automatic applyStimulus(input string name, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        checkOutput({name, ".req_ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clock);
    endtask

    // Watch the bus until the response, check it, hold it, then hand it off
    task automatic collectResponse(input string name, input logic [63:0] addr,
                                   input logic [63:0] expData, input logic expMis,
                                   input logic expFault, input int expLat, input int expWrites,
                                   input int expReads, input int holdCycles, input bit presentNext,
                                   output logic [63:0] obsData);
        int lat = 0, nW = 0, nR = 0;
        bit both = 0, unaligned = 0, gotResp = 0;
        logic [63:0] wAddr = '0;
        logic [63:0] d0;
        logic m0, f0;
        while (!gotResp && lat < 20) begin
            @(negedge clock);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.mem_read) nR++;
            if (bus.mem_write) begin nW++; wAddr = bus.mem_addr; end
            if (bus.mem_read && bus.mem_write) both = 1;
            if ((bus.mem_read || bus.mem_write) && bus.mem_addr[2:0] != 3'd0) unaligned = 1;
            if (bus.resp_valid) gotResp = 1;
        end
        obsData = bus.resp_rdata;
        checkOutput({name, ".resp_seen"}, 64'(gotResp), 64'd1);
        checkOutput({name, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, ".rdata"}, bus.resp_rdata, expData);
        checkOutput({name, ".misaligned"}, 64'(bus.resp_misaligned), 64'(expMis));
        checkOutput({name, ".access_fault"}, 64'(bus.resp_access_fault), 64'(expFault));
        checkOutput({name, ".write_pulses"}, 64'(nW), 64'(expWrites));
        checkOutput({name, ".read_pulses"}, 64'(nR), 64'(expReads));
        checkOutput({name, ".rd_wr_overlap"}, 64'(both), 64'd0);
        checkOutput({name, ".bus_unaligned"}, 64'(unaligned), 64'd0);
        if (expWrites != 0) checkOutput({name, ".write_addr"}, wAddr, {addr[63:3], 3'b000});
        d0 = bus.resp_rdata; m0 = bus.resp_misaligned; f0 = bus.resp_access_fault;
        if (presentNext) begin
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b011;
            bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
        end
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clock);
            checkOutput({name, ".hold_valid"}, 64'(bus.resp_valid), 64'd1);
            checkOutput({name, ".hold_rdata"}, bus.resp_rdata, d0);
            checkOutput({name, ".hold_flags"}, {62'd0, bus.resp_misaligned, bus.resp_access_fault}, {62'd0, m0, f0});
            checkOutput({name, ".hold_req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready = 1'b0;
        checkOutput({name, ".valid_dropped"}, 64'(bus.resp_valid), 64'd0);
        checkOutput({name, ".back_to_idle"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic runTxn(input string name, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd, input int hold,
                          output logic [63:0] obsData);
        logic [63:0] eD; logic eM, eF; int eL, eW, eR;
        modelRequest(wr, f3, addr, wd, eD, eM, eF, eL, eW, eR);
        applyStimulus(name, wr, f3, addr, wd);
        collectResponse(name, addr, eD, eM, eF, eL, eW, eR, hold, 1'b0, obsData);
    endtask

    // Directed steps, reset-in-write, then random traffic
    initial begin
        logic [63:0] obs;
        logic [63:0] eD; logic eM, eF; int eL, eW, eR;
        logic wr; logic [2:0] f3; logic [63:0] addr, wd; int sz;

        reset = 1'b1; presetMem = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'(i);
        repeat (2) @(negedge clock);
        checkOutput("reset.resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("reset.mem_access", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
        checkOutput("reset.req_ready_gated", 64'(bus.req_ready), 64'd0);
        reset = 1'b0; presetMem = 1'b0;
        #1;
        checkOutput("reset.req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clock);

        runTxn("ld08", 1'b0, 3'b011, 64'h08, 64'h0, 0, obs);
        checkOutput("ld08.const", obs, 64'h0F0E0D0C0B0A0908);
        runTxn("sb11", 1'b1, 3'b000, 64'h11, 64'hAA, 0, obs);
        checkOutput("sb11.rdata_zero", obs, 64'h0);
        runTxn("ld10", 1'b0, 3'b011, 64'h10, 64'h0, 0, obs);
        checkOutput("ld10.const", obs, 64'h171615141312AA10);
        runTxn("sb20", 1'b1, 3'b000, 64'h20, 64'h80, 1, obs);
        runTxn("lb20", 1'b0, 3'b000, 64'h20, 64'h0, 0, obs);
        checkOutput("lb20.const", obs, 64'hFFFFFFFFFFFFFF80);
        runTxn("lbu20", 1'b0, 3'b100, 64'h20, 64'h0, 0, obs);
        checkOutput("lbu20.const", obs, 64'h0000000000000080);
        runTxn("lhu22", 1'b0, 3'b101, 64'h22, 64'h0, 0, obs);
        checkOutput("lhu22.const", obs, 64'h0000000000002322);
        runTxn("lh03", 1'b0, 3'b001, 64'h03, 64'h0, 0, obs);
        runTxn("sd40", 1'b1, 3'b011, 64'h40, 64'h1122334455667788, 0, obs);
        runTxn("ld_f3_111", 1'b0, 3'b111, 64'h08, 64'h0, 0, obs);
        runTxn("sd38", 1'b1, 3'b011, 64'h38, 64'hCAFEF00D12345678, 0, obs);
        runTxn("huge", 1'b0, 3'b000, 64'hFFFFFFFFFFFFFFF8, 64'h0, 0, obs);

        // Held response with a competing request waiting behind it
        modelRequest(1'b0, 3'b011, 64'h08, 64'h0, eD, eM, eF, eL, eW, eR);
        applyStimulus("hold", 1'b0, 3'b011, 64'h08, 64'h0);
        collectResponse("hold", 64'h08, eD, eM, eF, eL, eW, eR, 3, 1'b1, obs);
        modelRequest(1'b0, 3'b011, 64'h00, 64'h0, eD, eM, eF, eL, eW, eR);
        @(posedge clock);
        collectResponse("queued", 64'h00, eD, eM, eF, eL, eW, eR, 0, 1'b0, obs);
        checkOutput("queued.const", obs, 64'h0706050403020100);

        // Reset landing in the WRITE cycle of a partial store
        applyStimulus("rst_sw", 1'b1, 3'b010, 64'h18, 64'hDEADBEEF);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        checkOutput("rst_sw.in_write", 64'(bus.mem_write), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_sw.write_gated", 64'(bus.mem_write), 64'd0);
        @(negedge clock);
        checkOutput("rst_sw.resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_sw.flags", {62'd0, bus.resp_misaligned, bus.resp_access_fault}, 64'd0);
        checkOutput("rst_sw.mem_rw", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
        checkOutput("rst_sw.rdata", bus.resp_rdata, 64'd0);
        checkOutput("rst_sw.mem_addr", bus.mem_addr, 64'd0);
        checkOutput("rst_sw.mem_wdata", bus.mem_wdata, 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_sw.req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clock);
        runTxn("ld18", 1'b0, 3'b011, 64'h18, 64'h0, 0, obs);
        checkOutput("ld18.const", obs, 64'h1F1E1D1C1B1A1918);

        // Random traffic against the byte-level model
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom};
            else addr = 64'($urandom_range(0, 71));
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
            wd = {$urandom, $urandom};
            runTxn($sformatf("rnd%0d", n), wr, f3, addr, wd, int'($urandom_range(0, 2)), obs);
        end

        for (int d = 0; d < MEM_BYTES / 8; d++) begin
            logic [63:0] envD, refD;
            for (int i = 0; i < 8; i++) begin
                envD[8*i +: 8] = envMem[8*d + i];
                refD[8*i +: 8] = refMem[8*d + i];
            end
            checkOutput($sformatf("final_mem%0d", d), envD, refD);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
